// File: rtl/softmax_vector_decoder.sv
// Decodes a stream of pseudo-float softmax elements into per-vector sum, max,
// argmax and element count; one result per vector with valid/ready handoff.
module softmax_vector_decoder #(
  parameter int unsigned MAX_LEN = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_mant,
  input  logic [2:0]  in_exp,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_sum,
  output logic [8:0]  out_max,
  output logic [2:0]  out_argmax,
  output logic [3:0]  out_count,
  output logic        out_len_err
);

  localparam int unsigned SUM_W  = 12;
  localparam int unsigned FX_W   = 9;
  localparam int unsigned MANT_W = 4;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned CNT_W  = 4;

  localparam logic STATE_ACC  = 1'b0;
  localparam logic STATE_DONE = 1'b1;

  logic              state;
  logic              state_next;
  logic [IDX_W-1:0]  idx;
  logic [MANT_W-1:0] mant_c;
  logic [FX_W-1:0]   fx_c;
  logic              accept_c;
  logic              at_limit_c;
  logic              close_c;

  // Element decode: implicit leading one, scaled to Q1.8, then shifted down.
  assign mant_c     = MANT_W'(4'd8 + {1'b0, in_mant});
  assign fx_c       = {mant_c, 5'b0_0000} >> in_exp;
  assign accept_c   = in_valid && (state == STATE_ACC);
  assign at_limit_c = (out_count == CNT_W'(MAX_LEN - 1));
  assign close_c    = accept_c && (in_last || at_limit_c);

  assign in_ready  = (state == STATE_ACC);
  assign out_valid = (state == STATE_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= STATE_ACC;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      STATE_ACC:  if (close_c)   state_next = STATE_DONE;
      default:    if (out_ready) state_next = STATE_ACC;
    endcase
  end

  // Accumulation datapath; frozen in DONE until the result is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_sum     <= '0;
      out_max     <= '0;
      out_argmax  <= '0;
      out_count   <= '0;
      out_len_err <= 1'b0;
      idx         <= '0;
    end else if (state == STATE_DONE) begin
      if (out_ready) begin
        out_sum     <= '0;
        out_max     <= '0;
        out_argmax  <= '0;
        out_count   <= '0;
        out_len_err <= 1'b0;
        idx         <= '0;
      end
    end else if (accept_c) begin
      out_sum   <= SUM_W'(out_sum + SUM_W'(fx_c));
      out_count <= CNT_W'(out_count + CNT_W'(1));
      idx       <= IDX_W'(idx + IDX_W'(1));
      // Strict compare keeps the earliest index on ties.
      if ((out_count == '0) || (fx_c > out_max)) begin
        out_max    <= fx_c;
        out_argmax <= idx;
      end
      out_len_err <= at_limit_c && !in_last;
    end
  end

endmodule

// File: tb/tb_softmax_vector_decoder.sv
// Self-checking bench: list-based reference model checked every cycle,
// directed vectors with hand-computed results, then randomized traffic.
module tb_softmax_vector_decoder;

  localparam int MAX_LEN = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_mant;
  logic [2:0]  in_exp;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_sum;
  logic [8:0]  out_max;
  logic [2:0]  out_argmax;
  logic [3:0]  out_count;
  logic        out_len_err;

  int n_checks = 0;
  int n_fail   = 0;

  softmax_vector_decoder #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_exp(in_exp), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_max(out_max), .out_argmax(out_argmax), .out_count(out_count),
    .out_len_err(out_len_err)
  );

  always #5 clk = ~clk;

  // Reference model: the accepted elements of the open vector, plus a result.
  int q_fx[$];
  bit m_done = 1'b0;
  int e_sum, e_max, e_arg, e_cnt;
  bit e_err;

  function automatic int fx_of(input int m, input int e);
    return ((8 + m) * 32) >> e;
  endfunction

  task automatic close_vector(input bit err);
    e_sum = 0; e_max = -1; e_arg = 0;
    foreach (q_fx[i]) begin
      e_sum += q_fx[i];
      if (q_fx[i] > e_max) begin e_max = q_fx[i]; e_arg = i; end
    end
    e_cnt  = q_fx.size();
    e_err  = err;
    m_done = 1'b1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q_fx.delete();
      m_done = 1'b0;
    end else if (m_done) begin
      if (out_ready) begin m_done = 1'b0; q_fx.delete(); end
    end else if (in_valid) begin
      q_fx.push_back(fx_of(int'(in_mant), int'(in_exp)));
      if (in_last || q_fx.size() == MAX_LEN) close_vector(!in_last);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of the DUT against the model.
  task automatic compare();
    chk("in_ready", int'(in_ready), int'(!m_done));
    chk("out_valid", int'(out_valid), int'(m_done));
    if (m_done && out_valid) begin
      chk("sum", int'(out_sum), e_sum);
      chk("max", int'(out_max), e_max);
      chk("argmax", int'(out_argmax), e_arg);
      chk("count", int'(out_count), e_cnt);
      chk("len_err", int'(out_len_err), int'(e_err));
    end
  endtask

  task automatic drive(input bit v, input int m, input int e, input bit l, input bit r);
    @(negedge clk);
    compare();
    in_valid  = v;
    in_mant   = 3'(m);
    in_exp    = 3'(e);
    in_last   = l;
    out_ready = r;
  endtask

  task automatic idle();
    drive(1'b0, int'($urandom_range(7)), int'($urandom_range(7)), 1'($urandom_range(1)), 1'b0);
  endtask

  // Wait for a result, pin it against literal values, optionally consume it.
  task automatic expect_result(input string name, input int s, input int mx, input int ag,
                               input int cnt, input int err, input bit consume);
    int waited;
    waited = 0;
    while (!out_valid && waited < 20) begin
      idle();
      waited++;
    end
    chk({name, "_latency"}, waited, 1);
    chk({name, "_sum"}, int'(out_sum), s);
    chk({name, "_max"}, int'(out_max), mx);
    chk({name, "_argmax"}, int'(out_argmax), ag);
    chk({name, "_count"}, int'(out_count), cnt);
    chk({name, "_len_err"}, int'(out_len_err), err);
    if (consume) begin
      drive(1'b0, 0, 0, 1'b0, 1'b1);
      drive(1'b0, 0, 0, 1'b0, 1'b0);
      chk({name, "_consumed"}, int'(out_valid), 0);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    compare();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_data", int'(out_sum) + int'(out_max) + int'(out_argmax) + int'(out_count) + int'(out_len_err), 0);
    @(negedge clk);
    compare();
    rst = 1'b0;
  endtask

  initial begin
    int hold_sum;
    rst = 1'b1; in_valid = 1'b0; in_mant = '0; in_exp = '0; in_last = 1'b0; out_ready = 1'b0;
    #1;
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_sum", int'(out_sum), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Nominal vector
    drive(1, 0, 1, 0, 0); drive(1, 4, 2, 0, 0); drive(1, 0, 0, 1, 0);
    expect_result("nominal", 480, 256, 2, 3, 0, 1'b1);

    // Tie keeps lower index
    drive(1, 0, 1, 0, 0); drive(1, 0, 1, 1, 0);
    expect_result("tie", 256, 128, 0, 2, 0, 1'b1);

    // Length overflow, then backpressure with ignored beats
    for (int i = 0; i < 8; i++) drive(1, 7, 0, 0, 0);
    expect_result("overflow", 3840, 480, 0, 8, 1, 1'b0);
    chk("overflow_in_ready", int'(in_ready), 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, int'($urandom_range(7)), int'($urandom_range(7)), 1'($urandom_range(1)), 0);
      chk("bp_sum", int'(out_sum), 3840);
      chk("bp_count", int'(out_count), 8);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    chk("bp_release_valid", int'(out_valid), 0);
    chk("bp_release_ready", int'(in_ready), 1);

    // Max-length vector closed by in_last on the final beat
    for (int i = 0; i < 7; i++) drive(1, 0, 7, 0, 0);
    drive(1, 1, 7, 1, 0);
    expect_result("exact_len", 7 * 2 + 2, 2, 0, 8, 0, 1'b1);

    // Mid-vector reset discards partial vector
    drive(1, 5, 0, 0, 0); drive(1, 6, 1, 0, 0);
    pulse_reset();
    drive(1, 2, 3, 1, 0);
    expect_result("mid_reset", 40, 40, 0, 1, 0, 1'b1);

    // Exponent extremes; second result is dropped by reset while pending
    drive(1, 7, 7, 1, 0);
    expect_result("exp_min", 3, 3, 0, 1, 0, 1'b1);
    drive(1, 0, 0, 1, 0);
    expect_result("exp_max", 256, 256, 0, 1, 0, 1'b0);
    pulse_reset();

    // Randomized traffic with occasional resets
    hold_sum = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(299) == 0) begin
        pulse_reset();
      end else begin
        drive(1'($urandom_range(9) < 7), int'($urandom_range(7)), int'($urandom_range(7)),
              1'($urandom_range(4) == 0), 1'($urandom_range(1)));
        if (out_valid) hold_sum++;
      end
    end
    chk("random_results_seen", int'(hold_sum > 0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
